// File: rtl/barret_sweep_1693.sv
// barret_sweep_1693
// Sweeps an operand range through an external mod-MODULUS reducer. For each
// operand it compares the reducer result against a running expected remainder.
// The expected remainder is computed once, by shift-subtract over 21 cycles.
// After that it only increments with wrap, so no divider exists in steady state.
//
// Parameters:
//   MODULUS - reduction modulus (default 1693)
//   SETTLE  - cycles the operand is held on dut_din before sampling (1..15)
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start                 - sweep request, accepted only when idle
//   start_val, end_val    - inclusive operand range, captured on accept
//   dut_din / dut_dout    - operand to / remainder from the reducer under test
//   busy, done            - sweep in progress / one-cycle end-of-sweep pulse
//   check_count           - operands checked (saturating)
//   err_count             - mismatches (saturating)
//   first_err_val/_dout/_vld - first mismatch record
//
// Optional feature macro: SWEEP_FIRST_ERR_EN
//   When defined, the first mismatch record is captured.
//   When undefined, the first_err_* outputs are tied to zero.
module barret_sweep_1693 #(
  parameter int unsigned MODULUS = 1693,
  parameter int unsigned SETTLE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [20:0] start_val,
  input  logic [20:0] end_val,
  output logic [20:0] dut_din,
  input  logic [10:0] dut_dout,
  output logic        busy,
  output logic        done,
  output logic [21:0] check_count,
  output logic [21:0] err_count,
  output logic [20:0] first_err_val,
  output logic [10:0] first_err_dout,
  output logic        first_err_vld
);

  localparam int unsigned OP_W  = 21;
  localparam int unsigned R_W   = 11;
  localparam int unsigned RX_W  = R_W + 1;
  localparam int unsigned CNT_W = 22;
  localparam int unsigned SET_W = 4;
  localparam int unsigned BIT_W = 5;

  localparam logic [RX_W-1:0] MOD_X = RX_W'(MODULUS);
  localparam logic [R_W-1:0]  MOD_M1 = R_W'(MODULUS - 1);

  typedef enum logic [2:0] {IDLE, INIT, DRIVE, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [OP_W-1:0]    end_q, end_d;
  logic [R_W-1:0]     rem_q, rem_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [RX_W-1:0]    trial;
  logic               accept;
  logic               mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // busy_q also blocks the done cycle, so a start is never taken mid-sweep.
  assign accept   = (state_q == IDLE) && start && !busy_q;
  assign mismatch = (state_q == CHECK) && (dut_dout != rem_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      end_q    <= '0;
      rem_q    <= '0;
      bit_q    <= '0;
      settle_q <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      end_q    <= end_d;
      rem_q    <= rem_d;
      bit_q    <= bit_d;
      settle_q <= settle_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath.
  // rem_q holds the partial remainder during INIT.
  // It then serves as the expected remainder.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    end_d    = end_q;
    rem_d    = rem_q;
    bit_d    = bit_q;
    settle_d = settle_q;
    chk_d    = chk_q;
    err_d    = err_q;
    trial    = {rem_q, op_q[bit_q]};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = start_val;
          end_d   = end_val;
          rem_d   = '0;
          bit_d   = BIT_W'(OP_W - 1);
          chk_d   = '0;
          err_d   = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        // An empty range is resolved here, so no reduction work is done for it.
        if (end_q < op_q) begin
          state_d = DONE;
        end else begin
          rem_d = (trial >= MOD_X) ? R_W'(trial - MOD_X) : R_W'(trial);
          if (bit_q == '0) begin
            settle_d = '0;
            state_d  = DRIVE;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end
      end
      DRIVE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      CHECK: begin
        chk_d = sat_inc(chk_q);
        if (mismatch) err_d = sat_inc(err_q);
        // Stop on equality, so an end_val of all-ones never wraps the operand.
        if (op_q == end_q) begin
          state_d = DONE;
        end else begin
          op_d     = op_q + OP_W'(1);
          rem_d    = (rem_q == MOD_M1) ? '0 : rem_q + R_W'(1);
          settle_d = '0;
          state_d  = DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (state_q == DONE);
    done_d = (state_q == DONE);
  end

  assign dut_din     = op_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign check_count = chk_q;
  assign err_count   = err_q;

`ifdef SWEEP_FIRST_ERR_EN
  logic [OP_W-1:0] fval_q;
  logic [R_W-1:0]  fdout_q;
  logic            fvld_q;

  // Record only the first mismatch; clear the record on each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      fval_q  <= '0;
      fdout_q <= '0;
      fvld_q  <= 1'b0;
    end else if (accept) begin
      fval_q  <= '0;
      fdout_q <= '0;
      fvld_q  <= 1'b0;
    end else if (mismatch && !fvld_q) begin
      fval_q  <= op_q;
      fdout_q <= dut_dout;
      fvld_q  <= 1'b1;
    end
  end

  assign first_err_val  = fval_q;
  assign first_err_dout = fdout_q;
  assign first_err_vld  = fvld_q;
`else
  assign first_err_val  = '0;
  assign first_err_dout = '0;
  assign first_err_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_barret_sweep_1693.sv
// Directed bench for barret_sweep_1693.
// A behavioural reducer (plain %) sits on dut_din/dut_dout.
// It has optional fault operands.
module tb_barret_sweep_1693;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [20:0] start_val;
  logic [20:0] end_val;
  logic [20:0] dut_din;
  logic [10:0] dut_dout;
  logic        busy;
  logic        done;
  logic [21:0] check_count;
  logic [21:0] err_count;
  logic [20:0] first_err_val;
  logic [10:0] first_err_dout;
  logic        first_err_vld;

  logic        fault_en;
  logic [20:0] fault_a;
  logic [20:0] fault_b;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  barret_sweep_1693 dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_val     (start_val),
    .end_val       (end_val),
    .dut_din       (dut_din),
    .dut_dout      (dut_dout),
    .busy          (busy),
    .done          (done),
    .check_count   (check_count),
    .err_count     (err_count),
    .first_err_val (first_err_val),
    .first_err_dout(first_err_dout),
    .first_err_vld (first_err_vld)
  );

  // Reference reducer, optionally returning 0 for up to two chosen operands.
  always_comb begin
    if (fault_en && (dut_din == fault_a || dut_din == fault_b)) dut_dout = '0;
    else dut_dout = 11'(dut_din % 21'd1693);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [20:0] s, input logic [20:0] e);
    @(negedge clk);
    start = 1'b1; start_val = s; end_val = e;
    @(negedge clk);
    start = 1'b0; start_val = '0; end_val = '0;
  endtask

  // Returns the number of edges after the start edge until done is seen.
  // It also checks the one-cycle done/busy pulse.
  task automatic wait_done(input string tag, output int c);
    c = 0;
    while (done !== 1'b1 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut_din"}, 32'(dut_din), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_check_count"}, 32'(check_count), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_first_err_val"}, 32'(first_err_val), 32'd0);
    check({tag, "_first_err_dout"}, 32'(first_err_dout), 32'd0);
    check({tag, "_first_err_vld"}, 32'(first_err_vld), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_val = '0; end_val = '0;
    fault_en = 1'b0; fault_a = '0; fault_b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Full residue sweep: 1 + 21 + 1693*2 edges to done.
    kick(21'd0, 21'd1692);
    wait_done("full", cyc);
    check("full_latency", 32'(cyc), 32'd3408);
    check("full_check_count", 32'(check_count), 32'd1693);
    check("full_err_count", 32'(err_count), 32'd0);
    check("full_first_vld", 32'(first_err_vld), 32'd0);

    // 3386 = 2*1693, so the expected remainder after INIT is 0.
    kick(21'd3386, 21'd3386);
    wait_done("single", cyc);
    check("single_check_count", 32'(check_count), 32'd1);
    check("single_err_count", 32'(err_count), 32'd0);

    // Expected remainder wraps 1692 -> 0 -> 1.
    kick(21'd1692, 21'd1694);
    wait_done("wrap", cyc);
    check("wrap_check_count", 32'(check_count), 32'd3);
    check("wrap_err_count", 32'(err_count), 32'd0);

    // Empty range.
    kick(21'd10, 21'd5);
    wait_done("empty", cyc);
    check("empty_latency", 32'(cyc), 32'd2);
    check("empty_check_count", 32'(check_count), 32'd0);
    check("empty_err_count", 32'(err_count), 32'd0);

    // Single faulted operand.
    fault_en = 1'b1; fault_a = 21'd1000; fault_b = 21'd1000;
    kick(21'd0, 21'd1692);
    wait_done("fault1", cyc);
    check("fault1_check_count", 32'(check_count), 32'd1693);
    check("fault1_err_count", 32'(err_count), 32'd1);
`ifdef SWEEP_FIRST_ERR_EN
    check("fault1_first_val", 32'(first_err_val), 32'd1000);
    check("fault1_first_dout", 32'(first_err_dout), 32'd0);
    check("fault1_first_vld", 32'(first_err_vld), 32'd1);
`else
    check("fault1_first_val", 32'(first_err_val), 32'd0);
    check("fault1_first_dout", 32'(first_err_dout), 32'd0);
    check("fault1_first_vld", 32'(first_err_vld), 32'd0);
`endif

    // Two faults: only the first is recorded.
    fault_b = 21'd1500;
    kick(21'd990, 21'd1510);
    wait_done("fault2", cyc);
    check("fault2_check_count", 32'(check_count), 32'd521);
    check("fault2_err_count", 32'(err_count), 32'd2);
`ifdef SWEEP_FIRST_ERR_EN
    check("fault2_first_val", 32'(first_err_val), 32'd1000);
    check("fault2_first_vld", 32'(first_err_vld), 32'd1);
`else
    check("fault2_first_val", 32'(first_err_val), 32'd0);
    check("fault2_first_vld", 32'(first_err_vld), 32'd0);
`endif
    fault_en = 1'b0;

    // A new start clears the error record.
    kick(21'd0, 21'd9);
    wait_done("clear", cyc);
    check("clear_check_count", 32'(check_count), 32'd10);
    check("clear_err_count", 32'(err_count), 32'd0);
    check("clear_first_vld", 32'(first_err_vld), 32'd0);

    // Top of operand range: terminates on equality without wrapping.
    kick(21'd2097150, 21'd2097151);
    wait_done("top", cyc);
    check("top_check_count", 32'(check_count), 32'd2);
    check("top_err_count", 32'(err_count), 32'd0);
    check("top_dut_din", 32'(dut_din), 32'd2097151);

    // Reset mid-sweep, with start asserted alongside reset.
    kick(21'd0, 21'd1692);
    cyc = 0;
    while (dut_din !== 21'd500 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_500", 32'(dut_din), 32'd500);
    rst = 1'b1; start = 1'b1; start_val = 21'd3; end_val = 21'd4;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    kick(21'd0, 21'd9);
    wait_done("after_rst", cyc);
    check("after_rst_check_count", 32'(check_count), 32'd10);
    check("after_rst_err_count", 32'(err_count), 32'd0);

    // A start raised during an active sweep is ignored.
    kick(21'd0, 21'd299);
    cyc = 0;
    while (dut_din !== 21'd200 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_start_reached_200", 32'(dut_din), 32'd200);
    start = 1'b1; start_val = 21'd5; end_val = 21'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", cyc);
    check("busy_start_check_count", 32'(check_count), 32'd300);
    check("busy_start_err_count", 32'(err_count), 32'd0);
    check("busy_start_dut_din", 32'(dut_din), 32'd299);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
